// File: rtl/apb4_mem_slave.sv
// APB4 completer fronting a DEPTH-word register memory.
// Byte-lane write strobes, configurable wait states, registered pready/prdata/pslverr,
// and an error response for misaligned or out-of-range addresses.
module apb4_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [3:0]            WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            phase;
    logic [1:0]            nxt;
    logic [3:0]            wait_cnt;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      word_idx;
    logic                  addr_err;
    logic                  xfer_ok;
    logic                  commit;

    assign word_addr = paddr >> OFF_W;
    assign word_idx  = word_addr[IDX_W-1:0];
    assign addr_err  = ((paddr & OFF_MASK) != '0) || (32'(word_addr) >= 32'(DEPTH));
    assign xfer_ok   = psel && penable;

    // Write lands on the edge that ends the single DONE cycle, only for a healthy transfer.
    assign commit    = (state == DONE) && xfer_ok && pwrite && !err_q;

    // SETUP is the bus setup cycle itself: decoded from the registered state plus the bus,
    // so that with zero wait states pready can be registered straight out of it.
    always_comb begin
        phase = state;
        if ((state == IDLE || state == DONE) && psel && !penable) begin
            phase = SETUP;
        end
    end

    // Next-state decode, including the abort path when the requester drops psel/penable early.
    always_comb begin
        nxt = IDLE;
        case (phase)
            IDLE:    nxt = IDLE;
            SETUP:   nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT: begin
                if (!xfer_ok) begin
                    nxt = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    nxt = DONE;
                end else begin
                    nxt = WAIT;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // FSM state, wait counter, latched error and the registered handshake outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
        end else begin
            state <= nxt;
            if (phase == SETUP) begin
                err_q    <= addr_err;
                wait_cnt <= WAIT_LOAD;
            end else if (phase == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            pready  <= (nxt == DONE);
            pslverr <= (nxt == DONE) && ((phase == SETUP) ? addr_err : err_q);
        end
    end

    // Read data is captured at the end of the setup cycle and held until the next read.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prdata <= '0;
        end else if (phase == SETUP && !pwrite) begin
            prdata <= addr_err ? '0 : mem[word_idx];
        end
    end

    // Word storage: cleared by reset, byte-lane masked writes on commit.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NB; k++) begin
                if (pstrb[k]) begin
                    mem[word_idx][8*k +: 8] <= pwdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed, table-driven bench for apb4_mem_slave: one instance with no wait states
// and one with three, sharing every bus input except psel.
module tb_apb4_mem_slave;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [9:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    logic        pready0, pslverr0;
    logic [31:0] prdata0;
    logic        pready3, pslverr3;
    logic [31:0] prdata3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
    );

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(16), .WAIT_CYCLES(3)) u_dut3 (
        .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
    );

    typedef struct {
        bit          inst;     // 0 = no wait states, 1 = three wait states
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          hold;     // keep psel high: next vector follows back-to-back
        logic [31:0] exp_rd;   // prdata during the pready cycle (held value for writes)
        bit          exp_err;
        int          exp_cyc;  // access cycle in which pready rises
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_pready(input bit inst);
        return inst ? pready3 : pready0;
    endfunction

    function automatic logic get_pslverr(input bit inst);
        return inst ? pslverr3 : pslverr0;
    endfunction

    function automatic logic [31:0] get_prdata(input bit inst);
        return inst ? prdata3 : prdata0;
    endfunction

    function automatic void add(input bit inst, input bit wr, input logic [9:0] addr,
                                input logic [31:0] data, input logic [3:0] strb, input bit hold,
                                input logic [31:0] exp_rd, input bit exp_err, input int exp_cyc);
        vec_t v;
        v.inst = inst; v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.hold = hold;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_cyc = exp_cyc;
        vecs.push_back(v);
    endfunction

    task automatic set_psel(input bit inst, input logic val);
        if (inst) psel3 = val;
        else      psel0 = val;
    endtask

    // One complete APB transfer; returns what was seen in the pready cycle.
    task automatic xfer(input string tag, input bit inst, input bit wr, input logic [9:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input bit hold,
                        output logic [31:0] rd, output logic er, output int cyc);
        @(posedge pclk); #1;
        set_psel(inst, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        @(negedge pclk);
        check({tag, "_setup_pready_low"}, 64'(get_pready(inst)), 64'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            cyc++;
            @(negedge pclk);
            if (get_pready(inst)) break;
            @(posedge pclk); #1;
        end
        rd = get_prdata(inst);
        er = get_pslverr(inst);
        if (!hold) begin
            @(posedge pclk); #1;
            set_psel(inst, 1'b0);
            penable = 1'b0;
            @(negedge pclk);
            check({tag, "_pready_one_cycle"}, 64'(get_pready(inst)), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        bit          saw_ready;

        // inst wr  addr    data          strb   hold exp_rd        err cyc
        add(0, 0, 10'h000, 32'h0,        4'h0,  0, 32'h00000000, 0, 1);
        add(0, 1, 10'h008, 32'hDEADBEEF, 4'hF,  0, 32'h00000000, 0, 1);
        add(0, 0, 10'h008, 32'h0,        4'h0,  0, 32'hDEADBEEF, 0, 1);
        add(0, 1, 10'h008, 32'h11223344, 4'h5,  0, 32'hDEADBEEF, 0, 1);
        add(0, 0, 10'h008, 32'h0,        4'h0,  0, 32'hDE22BE44, 0, 1);
        add(0, 0, 10'h00A, 32'h0,        4'h0,  0, 32'h00000000, 1, 1);
        add(0, 0, 10'h040, 32'h0,        4'h0,  0, 32'h00000000, 1, 1);
        add(0, 1, 10'h004, 32'hAAAA5555, 4'hF,  0, 32'h00000000, 0, 1);
        add(0, 1, 10'h006, 32'hFFFFFFFF, 4'hF,  0, 32'h00000000, 1, 1);
        add(0, 0, 10'h004, 32'h0,        4'h0,  0, 32'hAAAA5555, 0, 1);
        add(0, 0, 10'h008, 32'h0,        4'h0,  0, 32'hDE22BE44, 0, 1);
        add(0, 1, 10'h00C, 32'h12345678, 4'h0,  0, 32'hDE22BE44, 0, 1);
        add(0, 0, 10'h00C, 32'h0,        4'h0,  0, 32'h00000000, 0, 1);
        add(0, 0, 10'h03C, 32'h0,        4'h0,  0, 32'h00000000, 0, 1);
        add(1, 1, 10'h03C, 32'hCAFEF00D, 4'hF,  1, 32'h00000000, 0, 4);
        add(1, 0, 10'h03C, 32'h0,        4'h0,  0, 32'hCAFEF00D, 0, 4);
        add(1, 0, 10'h044, 32'h0,        4'h0,  0, 32'h00000000, 1, 4);

        // Reset
        repeat (2) @(posedge pclk);
        #1;
        check("rst_pready0",  64'(pready0),  64'd0);
        check("rst_pslverr0", 64'(pslverr0), 64'd0);
        check("rst_prdata0",  64'(prdata0),  64'd0);
        check("rst_pready3",  64'(pready3),  64'd0);
        check("rst_prdata3",  64'(prdata3),  64'd0);
        @(negedge pclk);
        presetn = 1'b1;

        // Table vectors
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            xfer(tag, vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].hold, rd, er, cyc);
            check({tag, "_cycles"},  64'(cyc), 64'(vecs[i].exp_cyc));
            check({tag, "_pslverr"}, 64'(er),  64'(vecs[i].exp_err));
            check({tag, "_prdata"},  64'(rd),  64'(vecs[i].exp_rd));
        end

        // Aborted write: psel drops in the second access cycle
        xfer("t5_seed", 1, 1, 10'h010, 32'h0BADF00D, 4'hF, 0, rd, er, cyc);
        check("t5_seed_cycles", 64'(cyc), 64'd4);
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 10'h010; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("t5_access1_pready", 64'(pready3), 64'd0);
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            if (pready3) saw_ready = 1'b1;
        end
        check("t5_no_pready_after_abort", 64'(saw_ready), 64'd0);
        xfer("t5_rd", 1, 0, 10'h010, 32'h0, 4'h0, 0, rd, er, cyc);
        check("t5_rd_cycles", 64'(cyc), 64'd4);
        check("t5_rd_pslverr", 64'(er), 64'd0);
        check("t5_rd_prdata", 64'(rd), 64'h0BADF00D);

        // Asynchronous reset in the middle of a WAIT state
        xfer("t6_seed", 1, 1, 10'h014, 32'h00000055, 4'hF, 0, rd, er, cyc);
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h014;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("t6_prdata_loaded", 64'(prdata3), 64'h55);
        #2;
        presetn = 1'b0;
        #1;
        check("t6_async_pready",  64'(pready3),  64'd0);
        check("t6_async_pslverr", 64'(pslverr3), 64'd0);
        check("t6_async_prdata",  64'(prdata3),  64'd0);
        @(negedge pclk);
        psel3 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        xfer("t6_rd14", 1, 0, 10'h014, 32'h0, 4'h0, 0, rd, er, cyc);
        check("t6_rd14_prdata", 64'(rd), 64'd0);
        xfer("t6_rd3c", 1, 0, 10'h03C, 32'h0, 4'h0, 0, rd, er, cyc);
        check("t6_rd3c_prdata", 64'(rd), 64'd0);
        xfer("t6_rd10", 1, 0, 10'h010, 32'h0, 4'h0, 0, rd, er, cyc);
        check("t6_rd10_prdata", 64'(rd), 64'd0);
        xfer("t6_dut0_rd08", 0, 0, 10'h008, 32'h0, 4'h0, 0, rd, er, cyc);
        check("t6_dut0_rd08_prdata", 64'(rd), 64'd0);
        check("t6_dut0_rd08_cycles", 64'(cyc), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
